// File: rtl/quad_port_bypass.sv
// Client-side front end for the 2-write/2-read quad memory.
// - Both write ports pass straight through. Port A is dropped when both ports
//   write the same address, so port B wins the tie.
// - A short history of effective writes forwards data to reads that hit an
//   address still in flight, which gives write-first behaviour.
// - Every read carries a valid strobe aligned to the fixed memory read latency.
//
// Valid semantics: there is no ready and no backpressure. An rd_* pulse is
// accepted unconditionally in its issue cycle, and rd_valid_* pulses exactly
// RD_LATENCY cycles later. A read may issue on each port every cycle.
module quad_port_bypass #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2,
  parameter int BYP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] wraddr_a,
  input  logic [ADDR_WIDTH-1:0] wraddr_b,
  input  logic [DATA_WIDTH-1:0] wrdat_a,
  input  logic [DATA_WIDTH-1:0] wrdat_b,
  input  logic                  rd_a,
  input  logic                  rd_b,
  input  logic [ADDR_WIDTH-1:0] rdaddr_a,
  input  logic [ADDR_WIDTH-1:0] rdaddr_b,
  output logic                  mem_we_a,
  output logic                  mem_we_b,
  output logic [ADDR_WIDTH-1:0] mem_wraddr_a,
  output logic [ADDR_WIDTH-1:0] mem_wraddr_b,
  output logic [DATA_WIDTH-1:0] mem_wrdat_a,
  output logic [DATA_WIDTH-1:0] mem_wrdat_b,
  output logic [ADDR_WIDTH-1:0] mem_rdaddr_a,
  output logic [ADDR_WIDTH-1:0] mem_rdaddr_b,
  input  logic [DATA_WIDTH-1:0] mem_rddat_a,
  input  logic [DATA_WIDTH-1:0] mem_rddat_b,
  output logic [DATA_WIDTH-1:0] rddat_a,
  output logic [DATA_WIDTH-1:0] rddat_b,
  output logic                  rd_valid_a,
  output logic                  rd_valid_b
);

  // With BYP_DEPTH==1 there are no history entries. One dummy entry is kept
  // for legal array bounds, and it is never marked valid.
  localparam int HIST     = (BYP_DEPTH > 1) ? BYP_DEPTH - 1 : 1;
  localparam bit HAS_HIST = (BYP_DEPTH > 1);
  localparam int LAST     = RD_LATENCY - 1;

  typedef struct packed {
    logic                  vld;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_ent_t;

  // Effective writes of the current cycle (after tie suppression).
  wr_ent_t cur_a, cur_b;

  // Write history, index 0 is newest.
  wr_ent_t [HIST-1:0] hist_a_q, hist_a_d;
  wr_ent_t [HIST-1:0] hist_b_q, hist_b_d;

  // Per-port read pipelines carrying {valid, hit, bypass data}.
  logic [RD_LATENCY-1:0]                 vld_a_q, vld_a_d;
  logic [RD_LATENCY-1:0]                 hit_a_q, hit_a_d;
  logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] dat_a_q, dat_a_d;
  logic [RD_LATENCY-1:0]                 vld_b_q, vld_b_d;
  logic [RD_LATENCY-1:0]                 hit_b_q, hit_b_d;
  logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] dat_b_q, dat_b_d;

  // Last delivered read data, held while no read completes.
  logic [DATA_WIDTH-1:0] hold_a_q, hold_a_d;
  logic [DATA_WIDTH-1:0] hold_b_q, hold_b_d;

  // Lookup results: {hit, data}.
  logic [DATA_WIDTH:0] lk_a, lk_b;

  // Search oldest to newest, with port A before port B inside each cycle.
  // Each later match overrides an earlier one, so the surviving match is the
  // newest write, and port B takes precedence within a cycle.
  function automatic logic [DATA_WIDTH:0] byp_lookup(
    input logic [ADDR_WIDTH-1:0] ra,
    input wr_ent_t               ca,
    input wr_ent_t               cb,
    input wr_ent_t [HIST-1:0]    ha,
    input wr_ent_t [HIST-1:0]    hb
  );
    logic                  hit;
    logic [DATA_WIDTH-1:0] dat;
    hit = 1'b0;
    dat = '0;
    for (int i = HIST - 1; i >= 0; i--) begin
      if (HAS_HIST && ha[i].vld && (ha[i].addr == ra)) begin
        hit = 1'b1;
        dat = ha[i].data;
      end
      if (HAS_HIST && hb[i].vld && (hb[i].addr == ra)) begin
        hit = 1'b1;
        dat = hb[i].data;
      end
    end
    if (ca.vld && (ca.addr == ra)) begin
      hit = 1'b1;
      dat = ca.data;
    end
    if (cb.vld && (cb.addr == ra)) begin
      hit = 1'b1;
      dat = cb.data;
    end
    return {hit, dat};
  endfunction

  // Address and data pass-through to the memory.
  assign mem_wraddr_a = wraddr_a;
  assign mem_wraddr_b = wraddr_b;
  assign mem_wrdat_a  = wrdat_a;
  assign mem_wrdat_b  = wrdat_b;
  assign mem_rdaddr_a = rdaddr_a;
  assign mem_rdaddr_b = rdaddr_b;

  // Write enables: nothing is written in reset, and port B wins a same-address tie.
  always_comb begin
    mem_we_b   = we_b & rst_n;
    mem_we_a   = we_a & rst_n & ~(we_b & (wraddr_a == wraddr_b));
    cur_a.vld  = mem_we_a;
    cur_a.addr = wraddr_a;
    cur_a.data = wrdat_a;
    cur_b.vld  = mem_we_b;
    cur_b.addr = wraddr_b;
    cur_b.data = wrdat_b;
  end

  // History shift: this cycle's effective writes enter at entry 0.
  always_comb begin
    hist_a_d = '0;
    hist_b_d = '0;
    if (HAS_HIST) begin
      hist_a_d[0] = cur_a;
      hist_b_d[0] = cur_b;
      for (int i = 1; i < HIST; i++) begin
        hist_a_d[i] = hist_a_q[i-1];
        hist_b_d[i] = hist_b_q[i-1];
      end
    end
  end

  // Bypass lookup for both read ports against the shared write window.
  always_comb begin
    lk_a = byp_lookup(rdaddr_a, cur_a, cur_b, hist_a_q, hist_b_q);
    lk_b = byp_lookup(rdaddr_b, cur_a, cur_b, hist_a_q, hist_b_q);
  end

  // Read pipelines: stage 0 captures the issue, and later stages shift.
  always_comb begin
    vld_a_d    = '0;
    hit_a_d    = '0;
    dat_a_d    = '0;
    vld_b_d    = '0;
    hit_b_d    = '0;
    dat_b_d    = '0;
    vld_a_d[0] = rd_a;
    hit_a_d[0] = lk_a[DATA_WIDTH];
    dat_a_d[0] = lk_a[DATA_WIDTH-1:0];
    vld_b_d[0] = rd_b;
    hit_b_d[0] = lk_b[DATA_WIDTH];
    dat_b_d[0] = lk_b[DATA_WIDTH-1:0];
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_a_d[i] = vld_a_q[i-1];
      hit_a_d[i] = hit_a_q[i-1];
      dat_a_d[i] = dat_a_q[i-1];
      vld_b_d[i] = vld_b_q[i-1];
      hit_b_d[i] = hit_b_q[i-1];
      dat_b_d[i] = dat_b_q[i-1];
    end
  end

  // Output select. Memory data arrives only in the completion cycle, so the
  // final mux works on registered pipeline state and the memory output register.
  always_comb begin
    rd_valid_a = vld_a_q[LAST];
    rd_valid_b = vld_b_q[LAST];
    rddat_a    = rd_valid_a ? (hit_a_q[LAST] ? dat_a_q[LAST] : mem_rddat_a) : hold_a_q;
    rddat_b    = rd_valid_b ? (hit_b_q[LAST] ? dat_b_q[LAST] : mem_rddat_b) : hold_b_q;
    hold_a_d   = rddat_a;
    hold_b_d   = rddat_b;
  end

  // State registers. Reset discards history and in-flight reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_a_q <= '0;
      hist_b_q <= '0;
      vld_a_q  <= '0;
      hit_a_q  <= '0;
      dat_a_q  <= '0;
      vld_b_q  <= '0;
      hit_b_q  <= '0;
      dat_b_q  <= '0;
      hold_a_q <= '0;
      hold_b_q <= '0;
    end else begin
      hist_a_q <= hist_a_d;
      hist_b_q <= hist_b_d;
      vld_a_q  <= vld_a_d;
      hit_a_q  <= hit_a_d;
      dat_a_q  <= dat_a_d;
      vld_b_q  <= vld_b_d;
      hit_b_q  <= hit_b_d;
      dat_b_q  <= dat_b_d;
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
    end
  end

endmodule

// File: tb/tb_quad_port_bypass.sv
// Directed bench for quad_port_bypass. It includes a quad memory model whose
// write commit is delayed by one cycle, so data still in flight must come
// from the bypass path.
module tb_quad_port_bypass;
  localparam int AW = 5;
  localparam int DW = 32;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          we_a, we_b, rd_a, rd_b;
  logic [AW-1:0] wraddr_a, wraddr_b, rdaddr_a, rdaddr_b;
  logic [DW-1:0] wrdat_a, wrdat_b;
  logic          mem_we_a, mem_we_b;
  logic [AW-1:0] mem_wraddr_a, mem_wraddr_b, mem_rdaddr_a, mem_rdaddr_b;
  logic [DW-1:0] mem_wrdat_a, mem_wrdat_b;
  logic [DW-1:0] mem_rddat_a, mem_rddat_b;
  logic [DW-1:0] rddat_a, rddat_b;
  logic          rd_valid_a, rd_valid_b;

  quad_port_bypass #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .BYP_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .we_a(we_a), .we_b(we_b),
    .wraddr_a(wraddr_a), .wraddr_b(wraddr_b),
    .wrdat_a(wrdat_a), .wrdat_b(wrdat_b),
    .rd_a(rd_a), .rd_b(rd_b),
    .rdaddr_a(rdaddr_a), .rdaddr_b(rdaddr_b),
    .mem_we_a(mem_we_a), .mem_we_b(mem_we_b),
    .mem_wraddr_a(mem_wraddr_a), .mem_wraddr_b(mem_wraddr_b),
    .mem_wrdat_a(mem_wrdat_a), .mem_wrdat_b(mem_wrdat_b),
    .mem_rdaddr_a(mem_rdaddr_a), .mem_rdaddr_b(mem_rdaddr_b),
    .mem_rddat_a(mem_rddat_a), .mem_rddat_b(mem_rddat_b),
    .rddat_a(rddat_a), .rddat_b(rddat_b),
    .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b)
  );

  // Memory model: the read address is registered, followed by an output
  // register. Writes commit one cycle after they are presented.
  logic [DW-1:0] mem_arr [32];
  logic          dw_we_a, dw_we_b;
  logic [AW-1:0] dw_addr_a, dw_addr_b;
  logic [DW-1:0] dw_dat_a, dw_dat_b;
  logic [DW-1:0] ra_q, rb_q;
  always @(posedge clk) begin
    dw_we_a   <= mem_we_a;
    dw_we_b   <= mem_we_b;
    dw_addr_a <= mem_wraddr_a;
    dw_addr_b <= mem_wraddr_b;
    dw_dat_a  <= mem_wrdat_a;
    dw_dat_b  <= mem_wrdat_b;
    if (dw_we_a) mem_arr[dw_addr_a] <= dw_dat_a;
    if (dw_we_b) mem_arr[dw_addr_b] <= dw_dat_b;
    ra_q        <= mem_arr[mem_rdaddr_a];
    rb_q        <= mem_arr[mem_rdaddr_b];
    mem_rddat_a <= ra_q;
    mem_rddat_b <= rb_q;
  end

  // Scoreboard state
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] exp_a [64];
  logic [DW-1:0] exp_b [64];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write-first reference: the newest write wins, and B wins a same-cycle tie.
  task automatic apply_ref();
    if (rst_n && we_a && !(we_b && wraddr_a == wraddr_b)) ref_mem[wraddr_a] = wrdat_a;
    if (rst_n && we_b) ref_mem[wraddr_b] = wrdat_b;
  endtask

  // Driver tasks
  task automatic idle();
    we_a = 1'b0; we_b = 1'b0; rd_a = 1'b0; rd_b = 1'b0;
  endtask

  task automatic tick();
    apply_ref();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    wraddr_a = '0; wraddr_b = '0; wrdat_a = '0; wrdat_b = '0;
    rdaddr_a = '0; rdaddr_b = '0;
    tick(); tick(); tick();

    // Reset state
    check("rst_valid_a", {31'd0, rd_valid_a}, 32'd0);
    check("rst_valid_b", {31'd0, rd_valid_b}, 32'd0);
    check("rst_rddat_a", rddat_a, 32'd0);
    check("rst_rddat_b", rddat_b, 32'd0);
    we_a = 1'b1; wraddr_a = 5'd1; we_b = 1'b1; wraddr_b = 5'd2;
    #1;
    check("rst_mem_we_a", {31'd0, mem_we_a}, 32'd0);
    check("rst_mem_we_b", {31'd0, mem_we_b}, 32'd0);
    tick();
    rst_n = 1'b1;
    idle();
    tick();

    // Fill the memory with known values: addr k holds 0x1000+k
    for (int k = 0; k < 16; k++) begin
      we_a = 1'b1; wraddr_a = 5'(2*k);   wrdat_a = 32'h1000 + 32'(2*k);
      we_b = 1'b1; wraddr_b = 5'(2*k+1); wrdat_b = 32'h1000 + 32'(2*k+1);
      tick();
    end
    idle();
    tick(); tick(); tick();

    // Test 1: a write three cycles before the read is served from memory
    we_a = 1'b1; wraddr_a = 5'd3; wrdat_a = 32'h11;
    tick();
    idle(); tick(); tick();
    rd_a = 1'b1; rdaddr_a = 5'd3;
    tick();
    idle();
    check("t1_valid_early", {31'd0, rd_valid_a}, 32'd0);
    tick();
    check("t1_valid", {31'd0, rd_valid_a}, 32'd1);
    check("t1_data", rddat_a, 32'h11);
    tick();
    check("t1_valid_drop", {31'd0, rd_valid_a}, 32'd0);
    check("t1_hold", rddat_a, 32'h11);

    // Test 2: same-address tie, port B wins and is forwarded
    we_a = 1'b1; wraddr_a = 5'd7; wrdat_a = 32'hAA;
    we_b = 1'b1; wraddr_b = 5'd7; wrdat_b = 32'hBB;
    rd_b = 1'b1; rdaddr_b = 5'd7; rdaddr_a = 5'd12;
    #1;
    check("t2_mem_we_a", {31'd0, mem_we_a}, 32'd0);
    check("t2_mem_we_b", {31'd0, mem_we_b}, 32'd1);
    check("t2_mem_wraddr_b", {27'd0, mem_wraddr_b}, 32'd7);
    check("t2_mem_wrdat_b", mem_wrdat_b, 32'hBB);
    check("t2_mem_rdaddr_b", {27'd0, mem_rdaddr_b}, 32'd7);
    check("t2_mem_rdaddr_a", {27'd0, mem_rdaddr_a}, 32'd12);
    tick();
    idle();
    tick();
    check("t2_valid", {31'd0, rd_valid_b}, 32'd1);
    check("t2_data", rddat_b, 32'hBB);

    // Test 3: a current-cycle A write beats the previous-cycle B write
    we_b = 1'b1; wraddr_b = 5'd5; wrdat_b = 32'h55;
    tick();
    idle();
    we_a = 1'b1; wraddr_a = 5'd5; wrdat_a = 32'h66;
    rd_a = 1'b1; rdaddr_a = 5'd5;
    tick();
    idle();
    tick();
    check("t3_valid", {31'd0, rd_valid_a}, 32'd1);
    check("t3_data", rddat_a, 32'h66);

    // Test 4: a write after the read does not affect it
    we_b = 1'b1; wraddr_b = 5'd9; wrdat_b = 32'h01;
    tick();
    idle(); tick(); tick(); tick(); tick();
    rd_b = 1'b1; rdaddr_b = 5'd9;
    tick();
    idle();
    we_a = 1'b1; wraddr_a = 5'd9; wrdat_a = 32'h99;
    tick();
    idle();
    check("t4_valid", {31'd0, rd_valid_b}, 32'd1);
    check("t4_data", rddat_b, 32'h01);
    tick(); tick();

    // Test 6: reset discards an in-flight read and ignores writes made in reset
    rd_a = 1'b1; rdaddr_a = 5'd3;
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    we_a = 1'b1; wraddr_a = 5'd20; wrdat_a = 32'hDEAD;
    check("t6_valid_t2", {31'd0, rd_valid_a}, 32'd0);
    check("t6_rddat_t2", rddat_a, 32'd0);
    tick();
    rst_n = 1'b1;
    idle();
    rd_a = 1'b1; rdaddr_a = 5'd20;
    check("t6_valid_t3", {31'd0, rd_valid_a}, 32'd0);
    check("t6_rddat_t3", rddat_a, 32'd0);
    tick();
    idle();
    check("t6_valid_t4", {31'd0, rd_valid_a}, 32'd0);
    check("t6_rddat_t4", rddat_a, 32'd0);
    tick();
    check("t6_post_valid", {31'd0, rd_valid_a}, 32'd1);
    check("t6_post_data", rddat_a, 32'h1014);
    tick();

    // Test 5: reads on both ports every cycle alongside random writes
    for (int i = 0; i < 66; i++) begin
      if (i >= 2) begin
        check("t5_valid_a", {31'd0, rd_valid_a}, 32'd1);
        check("t5_data_a", rddat_a, exp_a[i-2]);
        check("t5_valid_b", {31'd0, rd_valid_b}, 32'd1);
        check("t5_data_b", rddat_b, exp_b[i-2]);
      end
      if (i < 64) begin
        we_a = 1'($urandom_range(0, 1)); wraddr_a = 5'($urandom_range(0, 7)); wrdat_a = $urandom;
        we_b = 1'($urandom_range(0, 1)); wraddr_b = 5'($urandom_range(0, 7)); wrdat_b = $urandom;
        rd_a = 1'b1; rdaddr_a = 5'($urandom_range(0, 7));
        rd_b = 1'b1; rdaddr_b = 5'($urandom_range(0, 7));
        apply_ref();
        exp_a[i] = ref_mem[rdaddr_a];
        exp_b[i] = ref_mem[rdaddr_b];
      end else begin
        idle();
      end
      tick();
    end
    check("t5_end_valid_a", {31'd0, rd_valid_a}, 32'd0);
    check("t5_end_valid_b", {31'd0, rd_valid_b}, 32'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
